ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sequences the raw PS/2 scan-code byte stream from the PS/2 receiver into complete 16-bit key events {prefix, code}.
- Tracks held modifiers (CTRL, SHIFT, ALT) and the CAPS LOCK toggle.
- Buffers make/break events in a small FIFO with a valid/ready handshake.
- Sits between the PS/2 byte receiver and the keycode decode / RAM-command logic; those downstream blocks consume its 16-bit key words.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of o_count.

Ports:
- i_clk  in  1  system clock; all state on rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_data  in  8  scan-code byte from the PS/2 receiver
- i_valid  in  1  one-cycle strobe; i_data is valid this cycle
- i_err  in  1  receiver frame/parity error strobe
- o_key  out  16  head event code: 'h00xx for normal keys, 'he0xx for extended keys, 'he177 for PAUSE
- o_brk  out  1  head event is a break (release)
- o_valid  out  1  FIFO not empty
- i_ready  in  1  consumer pops the head when o_valid and i_ready are both high
- o_count  out  CNT_W  FIFO occupancy
- o_ovf  out  1  one-cycle pulse when an event is dropped because the FIFO is full
- o_ctrl  out  1  CTRL (L or R) currently held
- o_shft  out  1  SHIFT (L or R) currently held
- o_alt  out  1  ALT (L or R) currently held
- o_cslk  out  1  CAPS LOCK toggle state

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; FIFO is emptied.
  - o_valid=0, o_count=0, o_ovf=0, o_ctrl=o_shft=o_alt=o_cslk=0.
  - o_key='h0000, o_brk=0.
  - A partially received sequence is discarded.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on cycles with i_valid=1.
- IDLE:
  - 'he0 -> EXT.
  - 'hf0 -> BRK.
  - 'he1 -> PAUSE, skip counter := 7.
  - 'h00, 'haa, 'hee, 'hfa, 'hfe, 'hff -> ignored; stay in IDLE.
  - Any other byte b -> emit make 'h00b; stay in IDLE.
- EXT:
  - 'hf0 -> EXT_BRK.
  - Otherwise emit make 'he0b -> IDLE.
- BRK: emit break 'h00b -> IDLE.
- EXT_BRK: emit break 'he0b -> IDLE.
- PAUSE:
  - Each byte decrements the skip counter.
  - On the byte that takes the counter to 0: emit make 'he177 (no break is ever emitted) -> IDLE.
- Fake shifts: 'he012 and 'he059, make or break, are dropped entirely. They do not affect o_shft and are not pushed, so PRINT SCREEN appears only as 'he07c.
- i_err=1: FSM -> IDLE, skip counter cleared. i_err has priority over i_valid in the same cycle. FIFO and modifier state are untouched.
- Emit timing and latency:
  - An event is emitted in the same cycle its final byte is strobed.
  - It is written to the FIFO at that clock edge.
  - o_valid, o_key and o_brk reflect it from the next cycle when the FIFO was empty (1-cycle latency).
- Modifiers update at the emit edge, whether or not the FIFO accepts the event:
  - o_ctrl: set on make of 'h0014 / 'he014, cleared on their break.
  - o_shft: set on make of 'h0012 / 'h0059, cleared on their break.
  - o_alt: set on make of 'h0011 / 'he011, cleared on their break.
  - o_cslk: toggles on each make of 'h0058; its break has no effect.
- FIFO:
  - Show-ahead: o_key and o_brk always present the head entry.
  - Pop when o_valid && i_ready.
  - Push when an event is emitted and the FIFO is not full. Full with a simultaneous pop counts as not full, so the push succeeds and o_count is unchanged.
  - Full with no pop: the new event is dropped and o_ovf pulses for one cycle.
  - Empty with i_ready=1: no effect.
  - Pointers wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: PS2_KEY_CTRL_REPEAT_FILTER_EN.
- Defined:
  - A 16-bit last-held register records the code of the most recent pushed make.
  - A make equal to last-held is dropped as typematic repeat: no push, no o_ovf. Modifier handling for that make is unchanged, but it must not toggle o_cslk again.
  - A break whose code equals last-held clears the register to 'h0000.
  - Reset clears the register.
- Undefined: every make, including typematic repeats, is emitted and pushed.

Test Plan:
- Bytes 'h1c, 'hf0, 'h1c, i_ready=1 -> two events: ('h001c, brk=0), then ('h001c, brk=1); o_valid high 1 cycle after each final byte.
- Bytes 'he0, 'h14, then 'he0, 'hf0, 'h14 -> o_ctrl=1 after the 2nd byte and 0 after the 5th; events 'he014 make and 'he014 break.
- 'h58 make/break twice -> o_cslk goes 1 then 0; four events queued, o_count=4.
- Pause sequence 'he1,'h14,'h77,'he1,'hf0,'h14,'hf0,'h77 -> exactly one event 'he177 brk=0; o_shft/o_ctrl stay 0.
- i_ready=0, FIFO_DEPTH+1 makes -> o_count=FIFO_DEPTH; o_ovf pulses once; the popped order matches the first FIFO_DEPTH codes.
- 'he0, then i_err, then 'h5a -> event 'h005a (not 'he05a); assert i_rst mid-sequence after 'hf0 -> all outputs 0, next byte 'h1c yields a make.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: assembles {prefix, code} key events, tracks modifiers, queues events in a FIFO.
// Optional macro PS2_KEY_CTRL_REPEAT_FILTER_EN drops typematic repeats of the last held make.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic             i_err,
  output logic [15:0]      o_key,
  output logic             o_brk,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf,
  output logic             o_ctrl,
  output logic             o_shft,
  output logic             o_alt,
  output logic             o_cslk
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_skip;
  logic [2:0]        w_skip_nx;
  logic              w_emit;
  logic [15:0]       w_code;
  logic              w_brk;
  logic              w_fake;
  logic              w_emit_ok;
  logic              w_rep;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [16:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_ctrl;
  logic              r_shft;
  logic              r_alt;
  logic              r_cslk;

  // State and skip-counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_skip  <= w_skip_nx;
    end
  end

  // Next-state and event decode; a receiver error abandons any partial sequence
  always_comb begin
    w_state_nx = r_state;
    w_skip_nx  = r_skip;
    w_emit     = 1'b0;
    w_code     = 16'h0000;
    w_brk      = 1'b0;
    if (i_err) begin
      w_state_nx = S_IDLE;
      w_skip_nx  = 3'd0;
    end else if (i_valid) begin
      case (r_state)
        S_IDLE: begin
          case (i_data)
            8'he0: w_state_nx = S_EXT;
            8'hf0: w_state_nx = S_BRK;
            8'he1: begin
              w_state_nx = S_PAUSE;
              w_skip_nx  = 3'd7;
            end
            8'h00, 8'haa, 8'hee, 8'hfa, 8'hfe, 8'hff: w_state_nx = S_IDLE;
            default: begin
              w_emit = 1'b1;
              w_code = {8'h00, i_data};
            end
          endcase
        end
        S_EXT: begin
          if (i_data == 8'hf0) begin
            w_state_nx = S_EXT_BRK;
          end else begin
            w_emit     = 1'b1;
            w_code     = {8'he0, i_data};
            w_state_nx = S_IDLE;
          end
        end
        S_BRK: begin
          w_emit     = 1'b1;
          w_brk      = 1'b1;
          w_code     = {8'h00, i_data};
          w_state_nx = S_IDLE;
        end
        S_EXT_BRK: begin
          w_emit     = 1'b1;
          w_brk      = 1'b1;
          w_code     = {8'he0, i_data};
          w_state_nx = S_IDLE;
        end
        S_PAUSE: begin
          if (r_skip <= 3'd1) begin
            w_emit     = 1'b1;
            w_code     = 16'he177;
            w_skip_nx  = 3'd0;
            w_state_nx = S_IDLE;
          end else begin
            w_skip_nx = r_skip - 3'd1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_skip_nx  = 3'd0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Fake shifts surround PRINT SCREEN and friends; they never reach the modifiers or the FIFO
  assign w_fake    = (w_code == 16'he012) || (w_code == 16'he059);
  assign w_emit_ok = w_emit && !w_fake;

`ifdef PS2_KEY_CTRL_REPEAT_FILTER_EN
  logic [15:0] r_last;

  assign w_rep = w_emit_ok && !w_brk && (w_code == r_last);

  // Last-held make tracker for typematic repeat suppression
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 16'h0000;
    end else if (w_push && !w_brk) begin
      r_last <= w_code;
    end else if (w_emit_ok && w_brk && (w_code == r_last)) begin
      r_last <= 16'h0000;
    end else begin
      r_last <= r_last;
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  assign w_push_req = w_emit_ok && !w_rep;
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = o_valid && i_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Modifier tracking, independent of whether the FIFO accepts the event
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl <= 1'b0;
      r_shft <= 1'b0;
      r_alt  <= 1'b0;
      r_cslk <= 1'b0;
    end else if (w_emit_ok) begin
      if ((w_code == 16'h0014) || (w_code == 16'he014)) r_ctrl <= !w_brk;
      if ((w_code == 16'h0012) || (w_code == 16'h0059)) r_shft <= !w_brk;
      if ((w_code == 16'h0011) || (w_code == 16'he011)) r_alt  <= !w_brk;
      if ((w_code == 16'h0058) && !w_brk && !w_rep)     r_cslk <= !r_cslk;
    end else begin
      r_cslk <= r_cslk;
    end
  end

  // Event FIFO storage, pointers, occupancy and overflow pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 17'h00000;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_push_req && w_full && !w_pop;
      if (w_push) begin
        r_mem[r_wr] <= {w_brk, w_code};
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_key   = r_mem[r_rd][15:0];
  assign o_brk   = r_mem[r_rd][16];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_ctrl  = r_ctrl;
  assign o_shft  = r_shft;
  assign o_alt   = r_alt;
  assign o_cslk  = r_cslk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl (default FIFO_DEPTH=8).
module tb_ps2_key_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_data = 8'h00;
  logic          i_valid = 1'b0;
  logic          i_err = 1'b0;
  logic          i_ready = 1'b0;
  logic [15:0]   o_key;
  logic          o_brk;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_ovf;
  logic          o_ctrl;
  logic          o_shft;
  logic          o_alt;
  logic          o_cslk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [8];
  logic [7:0]  bytes9 [9];

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_err(i_err),
    .o_key(o_key), .o_brk(o_brk), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_ovf(o_ovf), .o_ctrl(o_ctrl), .o_shft(o_shft), .o_alt(o_alt), .o_cslk(o_cslk)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic pop();
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_key", o_key, 16'h0000);
    check("rst_brk", o_brk, 0);
    check("rst_mods", {o_ovf, o_ctrl, o_shft, o_alt, o_cslk}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // make/break of a plain key
    send(8'h1c);
    check("mk_valid", o_valid, 1);
    check("mk_key", o_key, 16'h001c);
    check("mk_brk", o_brk, 0);
    send(8'hf0);
    check("brk_pending_cnt", o_count, 1);
    send(8'h1c);
    check("mkbrk_cnt", o_count, 2);
    pop();
    check("brk_key", o_key, 16'h001c);
    check("brk_brk", o_brk, 1);
    pop();
    check("drain1_valid", o_valid, 0);

    // extended CTRL make/break
    send(8'he0);
    send(8'h14);
    check("ctrl_set", o_ctrl, 1);
    check("ext_key", o_key, 16'he014);
    send(8'he0);
    send(8'hf0);
    send(8'h14);
    check("ctrl_clr", o_ctrl, 0);
    check("ext_head_brk", o_brk, 0);
    pop();
    check("ext_brk_key", o_key, 16'he014);
    check("ext_brk_brk", o_brk, 1);
    pop();
    check("drain2_cnt", o_count, 0);

    // CAPS LOCK toggling
    send(8'h58);
    check("cslk_on", o_cslk, 1);
    send(8'hf0);
    send(8'h58);
    check("cslk_brk_keeps", o_cslk, 1);
    send(8'h58);
    check("cslk_off", o_cslk, 0);
    send(8'hf0);
    send(8'h58);
    check("cslk_cnt4", o_count, 4);
    for (int i = 0; i < 4; i++) begin
      check("cslk_q_key", o_key, 16'h0058);
      check("cslk_q_brk", o_brk, (i % 2 == 1) ? 1 : 0);
      pop();
    end
    check("drain3_cnt", o_count, 0);

    // PAUSE sequence
    send(8'he1); send(8'h14); send(8'h77); send(8'he1);
    send(8'hf0); send(8'h14); send(8'hf0);
    check("pause_wait_cnt", o_count, 0);
    send(8'h77);
    check("pause_cnt", o_count, 1);
    check("pause_key", o_key, 16'he177);
    check("pause_brk", o_brk, 0);
    check("pause_mods", {o_shft, o_ctrl}, 0);
    pop();

    // fill, overflow, then full with simultaneous pop
    bytes9 = '{8'h15, 8'h1d, 8'h24, 8'h2d, 8'h2c, 8'h35, 8'h3c, 8'h43, 8'h44};
    for (int i = 0; i < 8; i++) send(bytes9[i]);
    check("full_cnt", o_count, DEPTH);
    check("full_no_ovf", o_ovf, 0);
    send(bytes9[8]);
    check("ovf_pulse", o_ovf, 1);
    check("ovf_cnt", o_count, DEPTH);
    @(posedge i_clk);
    #1;
    check("ovf_once", o_ovf, 0);
    i_ready = 1'b1;
    send(8'h4b);
    i_ready = 1'b0;
    check("full_pushpop_cnt", o_count, DEPTH);
    check("full_pushpop_ovf", o_ovf, 0);
    for (int i = 0; i < 7; i++) exp_q[i] = {8'h00, bytes9[i + 1]};
    exp_q[7] = 16'h004b;
    for (int i = 0; i < 8; i++) begin
      check("order_key", o_key, exp_q[i]);
      pop();
    end
    check("drain4_cnt", o_count, 0);

    // fake shift is dropped
    send(8'he0);
    send(8'h12);
    check("fake_cnt", o_count, 0);
    check("fake_shft", o_shft, 0);

    // error aborts extended prefix
    send(8'he0);
    i_err = 1'b1;
    @(posedge i_clk);
    #1;
    i_err = 1'b0;
    send(8'h5a);
    check("err_key", o_key, 16'h005a);

    // async reset mid-sequence
    send(8'h12);
    send(8'h58);
    check("pre_rst_shft", o_shft, 1);
    send(8'hf0);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_cnt", o_count, 0);
    check("mid_rst_key", o_key, 16'h0000);
    check("mid_rst_mods", {o_brk, o_ovf, o_ctrl, o_shft, o_alt, o_cslk}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    send(8'h1c);
    check("post_rst_key", o_key, 16'h001c);
    check("post_rst_brk", o_brk, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
